dmem_arb_ctrl: RTL and testbench
================================

Name: dmem_arb_ctrl

Overview:
- Sequences every access to the word-only data RAM wrapper (16-bit byte address, single write enable, 32-bit read data, registered read).
- Shares that RAM between two requesters: the CPU MEM stage and the debug/program-loader port.
- Supports byte and halfword loads with sign/zero extension.
- Implements byte and halfword stores as read-modify-write, because the RAM has no byte enables.
- Sits between the MEM pipeline stage and the RAM wrapper. Drives the CPU stall.

Parameters:
- RD_LAT, 1, cycles from the RAM sampling an address to ram_rdata being valid (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- cpu_req  in  1  CPU access request. Held, with all cpu_* fields stable, until cpu_ready.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_size  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as word.
- cpu_uns  in  1  zero-extend sub-word load.
- cpu_addr  in  16  byte address.
- cpu_wdata  in  32  store data; sub-word value in its low bits.
- cpu_rdata  out  32  load result; valid while cpu_ready is high.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_err  out  1  misaligned access; valid with cpu_ready.
- cpu_stall  out  1  equals cpu_req & ~cpu_ready.
- dbg_req  in  1  loader request. Word only; held until dbg_ready.
- dbg_we  in  1  loader write.
- dbg_addr  in  16  byte address; bits [1:0] are ignored and forced to 00.
- dbg_wdata  in  32  loader write data.
- dbg_rdata  out  32  loader read data; valid with dbg_ready.
- dbg_ready  out  1  one-cycle completion pulse.
- ram_addr  out  16  byte address to the RAM wrapper.
- ram_wdata  out  32  write word.
- ram_wen  out  1  RAM write enable.
- ram_rdata  in  32  RAM read data.

Behaviour:
- Reset:
  - State goes to IDLE.
  - All outputs are 0: ram_wen, both ready signals, cpu_err, cpu_rdata, dbg_rdata, ram_addr, ram_wdata.
  - Last-grant flag is set to DBG, so the CPU wins the first conflict.
- FSM states are IDLE, RD_WAIT, WR, RESP. One access is in flight at a time.
- IDLE:
  - If any request is pending, grant it and latch its fields (cycle T).
  - Word store → WR.
  - Misaligned CPU access (half with addr[0]=1, or word with addr[1:0]≠0) → RESP with err set. No RAM access is made.
  - Otherwise (load or sub-word store) → RD_WAIT, with the wait counter loaded to RD_LAT.
- RD_WAIT:
  - ram_addr is driven from the latched address starting at T+1.
  - The state lasts RD_LAT+1 cycles. ram_rdata is captured in the last cycle.
  - Load → RESP.
  - Sub-word store → WR, with the merged word (new bytes inserted in their lanes, little-endian, other lanes kept).
- WR: ram_wen=1 for exactly one cycle with the latched ram_addr and ram_wdata, then → RESP.
- RESP:
  - The granted port's ready pulses for one cycle; rdata/err are valid in that cycle. Next state is IDLE.
  - The other port's ready stays 0.
- Latency from grant at T, with RD_LAT=1:
  - word store: ready at T+2.
  - load: ready at T+3.
  - sub-word store: ready at T+4.
  - misaligned: ready at T+1.
- Back-to-back requests: a new grant is possible in the IDLE cycle after RESP. Throughput is one access per (latency+1) cycles.
- Load extraction:
  - Byte lane is addr[1:0].
  - Byte: bit 7 is sign-extended unless cpu_uns.
  - Half: lane addr[1], bit 15 is sign-extended unless cpu_uns.
  - Word: passed through unchanged.
- Arbitration:
  - One requester pending → it is granted.
  - Both pending in IDLE → grant the port that was not last granted; the flag updates on grant.
  - A request arriving mid-access waits in IDLE; it is never dropped.
- ram_wen is asserted only in WR. It is decoded from the state register, so an asserted rst drops it immediately.
- Reset mid-operation aborts the access. No ready is issued; the requester must re-issue.
- cpu_rdata/dbg_rdata hold their last value outside RESP.

Decomposition:
- Package dmem_arb_pkg: SIZE_B/SIZE_H/SIZE_W encodings, the state enum, and the port-id constant (CPU=0, DBG=1).
- Sub-module dmem_lane (combinational):
  - load extraction/extension, taking (word, addr[1:0], size, uns);
  - store merge, taking (old word, new data, addr[1:0], size).

Test Plan:
- Word store then load: CPU SW 0xDEADBEEF @0x0010, then LW @0x0010 → ram_wen one cycle with ram_addr=0x0010; load returns 0xDEADBEEF with ready at T+3.
- Sub-word RMW: mem@0x0020=0x11223344; SB 0xAA @0x0021 → RAM written 0x1122AA44. Then SH 0xBEEF @0x0022 → 0xBEEFAA44.
- Load extension: mem@0x0030=0x80FF7F01.
  - LB @0x0032 → 0xFFFFFFFF; LBU @0x0032 → 0x000000FF.
  - LH @0x0032 → 0xFFFF80FF; LHU @0x0030 → 0x00007F01.
- Misalign: LW @0x0006 → cpu_err=1 at T+1, ram_wen never asserted, memory unchanged.
- Arbitration: cpu_req and dbg_req both held continuously from reset → grants alternate CPU, DBG, CPU, DBG. dbg_addr 0x0043 accesses word 0x0040.
- Reset mid-RMW: assert rst during RD_WAIT of SB → ram_wen stays 0, no ready pulse, memory unchanged, FSM is IDLE after release.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared encodings and types for the data-memory arbiter/sequencer.
package dmem_arb_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR      = 2'd2,
    RESP    = 2'd3
  } state_t;

  // Attributes of the access currently in flight
  typedef struct packed {
    logic       port;
    logic       we;
    logic [1:0] size;
    logic       uns;
    logic [1:0] lane;
  } acc_t;

  // Half needs an even address; word (and size 11) needs a 4-byte-aligned one
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SIZE_B:  misaligned = 1'b0;
      SIZE_H:  misaligned = lane[0];
      default: misaligned = (lane != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane.sv
// Byte-lane steering: sub-word load extraction/extension and store merge.
module dmem_lane
  import dmem_arb_pkg::*;
(
  input  logic [DATA_W-1:0] ld_word,
  input  logic [1:0]        lane,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [DATA_W-1:0] st_old,
  input  logic [DATA_W-1:0] st_new,
  output logic [DATA_W-1:0] ld_data_c,
  output logic [DATA_W-1:0] st_word_c
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Load: pick the lane, then sign- or zero-extend
  always_comb begin
    ld_byte   = ld_word[{lane, 3'b000} +: 8];
    ld_half   = lane[1] ? ld_word[31:16] : ld_word[15:0];
    ld_data_c = ld_word;
    case (size)
      SIZE_B:  ld_data_c = {{24{~uns & ld_byte[7]}}, ld_byte};
      SIZE_H:  ld_data_c = {{16{~uns & ld_half[15]}}, ld_half};
      default: ld_data_c = ld_word;
    endcase
  end

  // Store: overwrite only the addressed lanes of the old word
  always_comb begin
    st_word_c = st_old;
    case (size)
      SIZE_B:  st_word_c[{lane, 3'b000} +: 8]      = st_new[7:0];
      SIZE_H:  st_word_c[{lane[1], 4'b0000} +: 16] = st_new[15:0];
      default: st_word_c = st_new;
    endcase
  end

endmodule

// File: rtl/dmem_arb_ctrl.sv
// Arbitrates CPU and debug access to a word-only RAM; sub-word stores are
// done as read-modify-write.
module dmem_arb_ctrl
  import dmem_arb_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_size,
  input  logic              cpu_uns,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              cpu_err,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wen,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int unsigned CNT_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);

  state_t            state_q, state_d;
  acc_t              acc_q, acc_d;
  logic              last_gnt_q, last_gnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic [DATA_W-1:0] cpu_rdata_d, dbg_rdata_d;
  logic              cpu_ready_d, dbg_ready_d, cpu_err_d;
  logic              gnt_dbg;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] ld_data_c, st_word_c;

  dmem_lane u_lane (
    .ld_word   (ram_rdata),
    .lane      (acc_q.lane),
    .size      (acc_q.size),
    .uns       (acc_q.uns),
    .st_old    (ram_rdata),
    .st_new    (ram_wdata),
    .ld_data_c (ld_data_c),
    .st_word_c (st_word_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      last_gnt_q <= PORT_DBG;
      cnt_q      <= '0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      cpu_rdata  <= '0;
      dbg_rdata  <= '0;
      cpu_ready  <= 1'b0;
      dbg_ready  <= 1'b0;
      cpu_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      last_gnt_q <= last_gnt_d;
      cnt_q      <= cnt_d;
      ram_addr   <= addr_d;
      ram_wdata  <= wdata_d;
      cpu_rdata  <= cpu_rdata_d;
      dbg_rdata  <= dbg_rdata_d;
      cpu_ready  <= cpu_ready_d;
      dbg_ready  <= dbg_ready_d;
      cpu_err    <= cpu_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    last_gnt_d  = last_gnt_q;
    cnt_d       = cnt_q;
    addr_d      = ram_addr;
    wdata_d     = ram_wdata;
    cpu_rdata_d = cpu_rdata;
    dbg_rdata_d = dbg_rdata;
    cpu_ready_d = 1'b0;
    dbg_ready_d = 1'b0;
    cpu_err_d   = 1'b0;

    // On a conflict the port not granted last time wins
    gnt_dbg  = dbg_req & (~cpu_req | (last_gnt_q == PORT_CPU));
    req_addr = gnt_dbg ? dbg_addr : cpu_addr;

    case (state_q)
      IDLE: begin
        if (cpu_req | dbg_req) begin
          last_gnt_d = gnt_dbg ? PORT_DBG : PORT_CPU;
          acc_d.port = gnt_dbg ? PORT_DBG : PORT_CPU;
          acc_d.we   = gnt_dbg ? dbg_we : cpu_we;
          acc_d.size = gnt_dbg ? SIZE_W : cpu_size;
          acc_d.uns  = ~gnt_dbg & cpu_uns;
          acc_d.lane = gnt_dbg ? 2'b00 : req_addr[1:0];
          addr_d     = {req_addr[ADDR_W-1:2], 2'b00};
          wdata_d    = gnt_dbg ? dbg_wdata : cpu_wdata;
          cnt_d      = CNT_W'(RD_LAT);
          // Debug lane is forced to 0, so only the CPU can land here
          if (misaligned(acc_d.size, acc_d.lane)) begin
            state_d   = RESP;
            cpu_err_d = 1'b1;
          end else if (acc_d.we && acc_d.size[1]) begin
            state_d = WR;
          end else begin
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (cnt_q == CNT_W'(0)) begin
          if (acc_q.we) begin
            wdata_d = st_word_c;
            state_d = WR;
          end else begin
            if (acc_q.port == PORT_DBG) dbg_rdata_d = ram_rdata;
            else                        cpu_rdata_d = ld_data_c;
            state_d = RESP;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Ready pulses are registered: raised on entry to RESP
    if (state_d == RESP && state_q != RESP) begin
      if (acc_d.port == PORT_DBG) dbg_ready_d = 1'b1;
      else                        cpu_ready_d = 1'b1;
    end
  end

  assign ram_wen   = (state_q == WR);
  assign cpu_stall = cpu_req & ~cpu_ready;

endmodule

// File: tb/tb_dmem_arb_ctrl.sv
// Scoreboard bench for dmem_arb_ctrl with a behavioural registered-read RAM.
module tb_dmem_arb_ctrl;
  import dmem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, cpu_uns;
  logic [1:0]  cpu_size;
  logic [15:0] cpu_addr;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic        cpu_ready, cpu_err, cpu_stall;
  logic        dbg_req, dbg_we;
  logic [15:0] dbg_addr;
  logic [31:0] dbg_wdata, dbg_rdata;
  logic        dbg_ready;
  logic [15:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic        ram_wen;

  logic        bd_we;
  logic [15:0] bd_addr;
  logic [31:0] bd_data;
  logic [31:0] mem [0:16383];

  typedef struct {
    logic        port;
    logic        chk_data;
    logic [31:0] data;
    logic        err;
    int          lat;
    int          issued;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          wen_cnt = 0;
  logic [15:0] last_wr_addr = '0;

  always #5 clk = ~clk;

  dmem_arb_ctrl #(.RD_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_uns(cpu_uns),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_ready(cpu_ready), .cpu_err(cpu_err), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ready(dbg_ready),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wen(ram_wen), .ram_rdata(ram_rdata)
  );

  // Word RAM, one-cycle registered read; backdoor port for preloading
  always @(posedge clk) begin
    cyc <= cyc + 1;
    ram_rdata <= mem[ram_addr[15:2]];
    if (ram_wen)    mem[ram_addr[15:2]] <= ram_wdata;
    else if (bd_we) mem[bd_addr[15:2]]  <= bd_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per ready pulse
  always @(negedge clk) begin
    exp_t e;
    if (ram_wen) begin
      wen_cnt++;
      last_wr_addr = ram_addr;
    end
    if (cpu_ready || dbg_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_ready", {30'd0, dbg_ready, cpu_ready}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("ready_port", {31'd0, dbg_ready}, {31'd0, e.port});
        if (e.port == PORT_CPU) check("cpu_err", {31'd0, cpu_err}, {31'd0, e.err});
        if (e.chk_data) begin
          if (e.port == PORT_CPU) check("cpu_rdata", cpu_rdata, e.data);
          else                    check("dbg_rdata", dbg_rdata, e.data);
        end
        if (e.lat >= 0) check("latency", 32'(cyc - e.issued), 32'(e.lat));
      end
    end
  end

  task automatic bd_write(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic op(input logic port, input logic we, input logic [1:0] size, input logic uns,
                    input logic [15:0] addr, input logic [31:0] wdata, input logic chk,
                    input logic [31:0] exp_data, input logic exp_err, input int lat,
                    input int exp_wens);
    int w0;
    bit done;
    @(negedge clk);
    if (port == PORT_CPU) begin
      cpu_we = we; cpu_size = size; cpu_uns = uns; cpu_addr = addr; cpu_wdata = wdata;
      cpu_req = 1'b1;
    end else begin
      dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
      dbg_req = 1'b1;
    end
    w0 = wen_cnt;
    sb_q.push_back('{port, chk, exp_data, exp_err, lat, cyc});
    #1;
    if (port == PORT_CPU) check("stall_on_issue", {31'd0, cpu_stall}, 32'd1);
    done = 0;
    for (int i = 0; i < 30 && !done; i++) begin
      @(negedge clk);
      if ((port == PORT_CPU) ? cpu_ready : dbg_ready) done = 1;
    end
    if (!done) check("ready_timeout", 32'd0, 32'd1);
    #1;
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    check("wen_pulses", 32'(wen_cnt - w0), 32'(exp_wens));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    int w0;
    int seen;
    rst = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_size = 2'b00; cpu_uns = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    bd_we = 0; bd_addr = '0; bd_data = '0;

    bd_write(16'h0020, 32'h11223344);
    bd_write(16'h0030, 32'h80FF7F01);
    bd_write(16'h0040, 32'h12345678);
    bd_write(16'h0050, 32'h55667788);

    // Reset values
    @(negedge clk);
    check("rst_cpu_rdata", cpu_rdata, 32'd0);
    check("rst_dbg_rdata", dbg_rdata, 32'd0);
    check("rst_ready", {30'd0, dbg_ready, cpu_ready}, 32'd0);
    check("rst_cpu_err", {31'd0, cpu_err}, 32'd0);
    check("rst_ram_wen", {31'd0, ram_wen}, 32'd0);
    check("rst_ram_addr", {16'd0, ram_addr}, 32'd0);
    check("rst_ram_wdata", ram_wdata, 32'd0);
    rst = 1'b0;

    // Word store then load
    op(PORT_CPU, 1, SIZE_W, 0, 16'h0010, 32'hDEADBEEF, 0, 32'h0, 0, 2, 1);
    check("sw_wr_addr", {16'd0, last_wr_addr}, 32'h0010);
    check("sw_mem", mem[4], 32'hDEADBEEF);
    op(PORT_CPU, 0, SIZE_W, 0, 16'h0010, 32'h0, 1, 32'hDEADBEEF, 0, 3, 0);

    // Sub-word read-modify-write
    op(PORT_CPU, 1, SIZE_B, 0, 16'h0021, 32'h000000AA, 0, 32'h0, 0, 4, 1);
    check("sb_mem", mem[8], 32'h1122AA44);
    op(PORT_CPU, 1, SIZE_H, 0, 16'h0022, 32'h1234BEEF, 0, 32'h0, 0, 4, 1);
    check("sh_mem", mem[8], 32'hBEEFAA44);

    // Load extension on 0x80FF7F01
    op(PORT_CPU, 0, SIZE_B, 0, 16'h0032, 32'h0, 1, 32'hFFFFFFFF, 0, 3, 0);
    op(PORT_CPU, 0, SIZE_B, 1, 16'h0032, 32'h0, 1, 32'h000000FF, 0, 3, 0);
    op(PORT_CPU, 0, SIZE_H, 0, 16'h0032, 32'h0, 1, 32'hFFFF80FF, 0, 3, 0);
    op(PORT_CPU, 0, SIZE_H, 1, 16'h0030, 32'h0, 1, 32'h00007F01, 0, 3, 0);
    op(PORT_CPU, 0, SIZE_B, 0, 16'h0031, 32'h0, 1, 32'h0000007F, 0, 3, 0);
    op(PORT_CPU, 0, SIZE_B, 0, 16'h0033, 32'h0, 1, 32'hFFFFFF80, 0, 3, 0);
    op(PORT_CPU, 0, 2'b11,  0, 16'h0030, 32'h0, 1, 32'h80FF7F01, 0, 3, 0);

    // Misaligned accesses: error at T+1, no RAM write
    op(PORT_CPU, 0, SIZE_W, 0, 16'h0006, 32'h0, 0, 32'h0, 1, 1, 0);
    op(PORT_CPU, 1, SIZE_H, 0, 16'h0011, 32'h0000FFFF, 0, 32'h0, 1, 1, 0);
    check("misalign_mem", mem[4], 32'hDEADBEEF);

    // Debug port: low address bits ignored
    op(PORT_DBG, 1, SIZE_W, 0, 16'h0063, 32'hCAFEF00D, 0, 32'h0, 0, 2, 1);
    check("dbg_wr_addr", {16'd0, last_wr_addr}, 32'h0060);
    check("dbg_mem", mem[24], 32'hCAFEF00D);
    op(PORT_DBG, 0, SIZE_W, 0, 16'h0061, 32'h0, 1, 32'hCAFEF00D, 0, 3, 0);

    // Reset during RD_WAIT of a byte store
    @(negedge clk);
    w0 = wen_cnt;
    cpu_we = 1; cpu_size = SIZE_B; cpu_uns = 0; cpu_addr = 16'h0051; cpu_wdata = 32'h000000AA;
    cpu_req = 1'b1;
    @(negedge clk);
    check("rmw_in_rd_wait", 32'(dut.state_q), 32'(RD_WAIT));
    rst = 1'b1;
    #1;
    check("rst_drops_wen", {31'd0, ram_wen}, 32'd0);
    @(negedge clk);
    cpu_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("fsm_idle_after_rst", 32'(dut.state_q), 32'(IDLE));
    repeat (4) @(negedge clk);
    check("rst_rmw_no_wen", 32'(wen_cnt - w0), 32'd0);
    check("rst_rmw_mem", mem[20], 32'h55667788);

    // Both requesters held from reset: grants alternate CPU, DBG, CPU, DBG
    @(negedge clk);
    rst = 1'b1;
    cpu_we = 0; cpu_size = SIZE_W; cpu_uns = 0; cpu_addr = 16'h0010; cpu_req = 1'b1;
    dbg_we = 0; dbg_addr = 16'h0043; dbg_req = 1'b1;
    sb_q.push_back('{PORT_CPU, 1'b1, 32'hDEADBEEF, 1'b0, -1, 0});
    sb_q.push_back('{PORT_DBG, 1'b1, 32'h12345678, 1'b0, -1, 0});
    sb_q.push_back('{PORT_CPU, 1'b1, 32'hDEADBEEF, 1'b0, -1, 0});
    sb_q.push_back('{PORT_DBG, 1'b1, 32'h12345678, 1'b0, -1, 0});
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 60 && seen < 4; i++) begin
      @(negedge clk);
      if (cpu_ready || dbg_ready) seen++;
    end
    #1;
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    check("arb_grants", 32'(seen), 32'd4);

    repeat (6) @(negedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
